multicycle_controller: RTL

- Sequencing FSM that converts the processor datapath (PC, instruction memory, register file, ALU, data memory, muxes) from single-cycle to multicycle operation.
- Issues per-state enables, mux selects and ALU control. Waits on instruction/data memory acknowledges and holds the NZCV flag register.
- Evaluates ARM-style condition codes and reports run status: busy, halted, error, retired count.

---
 rtl/multicycle_controller.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle sequencing controller: walks the datapath through fetch, decode,
// execute, memory and writeback, pacing memory waits and holding the NZCV flags.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cond,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       alu_flags,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             result_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_ctrl,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_DP, S_WB_ALU, S_EXEC_MEM,
    S_MEM, S_WB_MEM, S_BRANCH, S_HALT, S_ERROR
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  // Last wait cycle index (counter starts at 0) in which an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [7:0]       wait_q, wait_d;
  logic             imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic             mem_we_q, mem_we_d, pc_we_q, pc_we_d, pc_src_q, pc_src_d;
  logic             reg_we_q, reg_we_d, result_src_q, result_src_d;
  logic             alu_src_b_q, alu_src_b_d;
  logic [1:0]       alu_ctrl_q, alu_ctrl_d;
  logic             busy_q, busy_d, halted_q, halted_d, error_q, error_d;

  logic [3:0] cmd;
  logic       cmd_valid, cmd_cmp, cond_pass, retire;
  logic       fn, fz, fc, fv;

  assign cmd     = funct[4:1];
  assign cmd_cmp = (cmd == CMD_CMP);
  assign {fn, fz, fc, fv} = flags_q;

  function automatic logic [1:0] dp_alu(input logic [3:0] c);
    case (c)
      CMD_ADD: dp_alu = 2'b00;
      CMD_SUB: dp_alu = 2'b01;
      CMD_AND: dp_alu = 2'b10;
      CMD_ORR: dp_alu = 2'b11;
      CMD_CMP: dp_alu = 2'b01;
      default: dp_alu = 2'b00;
    endcase
  endfunction

  always_comb begin
    cmd_valid = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                (cmd == CMD_ORR) || (cmd == CMD_CMP);
  end

  always_comb begin
    case (cond)
      4'h0:    cond_pass = fz;
      4'h1:    cond_pass = !fz;
      4'h2:    cond_pass = fc;
      4'h3:    cond_pass = !fc;
      4'h4:    cond_pass = fn;
      4'h5:    cond_pass = !fn;
      4'h6:    cond_pass = fv;
      4'h7:    cond_pass = !fv;
      4'h8:    cond_pass = fc && !fz;
      4'h9:    cond_pass = !fc || fz;
      4'hA:    cond_pass = (fn == fv);
      4'hB:    cond_pass = (fn != fv);
      4'hC:    cond_pass = !fz && (fn == fv);
      4'hD:    cond_pass = fz || (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack)                 state_d = S_DECODE;
        else if (wait_q >= WAIT_LAST) state_d = S_ERROR;
        else                          wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        if (op == 2'b11) state_d = S_HALT;
        else if (!cond_pass) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          case (op)
            2'b00:   state_d = S_EXEC_DP;
            2'b01:   state_d = S_EXEC_MEM;
            default: state_d = S_BRANCH;
          endcase
        end
      end
      S_EXEC_DP: begin
        if (!cmd_valid) state_d = S_ERROR;
        else begin
          if (funct[0] || cmd_cmp) flags_d = alu_flags;
          if (cmd_cmp) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB_ALU;
          end
        end
      end
      S_EXEC_MEM: state_d = S_MEM;
      S_MEM: begin
        if (dmem_ack) begin
          if (funct[0]) state_d = S_WB_MEM;
          else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_q >= WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) wait_d = '0;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Moore outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    imem_req_d   = (state_d == S_FETCH);
    dmem_req_d   = (state_d == S_MEM);
    mem_we_d     = (state_d == S_MEM) && !funct[0];
    pc_we_d      = (state_d == S_BRANCH);
    pc_src_d     = (state_d == S_BRANCH);
    reg_we_d     = (state_d == S_WB_ALU) || (state_d == S_WB_MEM);
    result_src_d = (state_d == S_WB_MEM);
    alu_src_b_d  = 1'b0;
    alu_ctrl_d   = 2'b00;
    case (state_d)
      S_EXEC_DP: begin
        alu_src_b_d = funct[5];
        alu_ctrl_d  = dp_alu(cmd);
      end
      S_EXEC_MEM, S_MEM: begin
        alu_src_b_d = 1'b1;
        alu_ctrl_d  = 2'b00;
      end
      default: ;
    endcase
    busy_d   = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERROR));
    halted_d = (state_d == S_HALT);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flags_q      <= '0;
      retired_q    <= '0;
      wait_q       <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_src_q     <= 1'b0;
      reg_we_q     <= 1'b0;
      result_src_q <= 1'b0;
      alu_src_b_q  <= 1'b0;
      alu_ctrl_q   <= 2'b00;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      retired_q    <= retired_d;
      wait_q       <= wait_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      mem_we_q     <= mem_we_d;
      pc_we_q      <= pc_we_d;
      pc_src_q     <= pc_src_d;
      reg_we_q     <= reg_we_d;
      result_src_q <= result_src_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
    end
  end

  // Fetch acceptance loads IR and advances PC in the ack cycle itself.
  assign ir_we      = (state_q == S_FETCH) && imem_ack;
  assign pc_we      = pc_we_q || ir_we;
  assign pc_src     = pc_src_q;
  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign mem_we     = mem_we_q;
  assign reg_we     = reg_we_q;
  assign result_src = result_src_q;
  assign alu_src_b  = alu_src_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign flags      = flags_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign error      = error_q;
  assign retired    = retired_q;

endmodule
